// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and helpers for the matmul operand path
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic MAT_A = 1'b0;
  localparam logic MAT_B = 1'b1;

  function automatic int max_dim_of(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int addr_w_of(input int max_dim);
    return (max_dim <= 1) ? 1 : $clog2(max_dim);
  endfunction

  // Low bit of element j in a row; slice with [elem_lo(j, dw) +: dw].
  function automatic int elem_lo(input int j, input int dw);
    return j * dw;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// rtl/operand_bank.sv - one operand matrix: strobed row write, registered read, row/column extract
module operand_bank
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_W     = 2,
  parameter bit COLUMN     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_row_i,
  input  logic [BUS_WIDTH-1:0] wr_data_i,
  input  logic [MAX_DIM-1:0]   wr_strb_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_W-1:0]    rd_row_i,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  input  logic [ADDR_W-1:0]    ext_sel_i,
  output logic [BUS_WIDTH-1:0] ext_o
);

  logic [BUS_WIDTH-1:0] mem [MAX_DIM];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < MAX_DIM; r++) mem[r] <= '0;
      rd_data_o <= '0;
    end else begin
      if (wr_en_i) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          if (wr_strb_i[j])
            mem[wr_row_i][elem_lo(j, DATA_WIDTH) +: DATA_WIDTH] <=
              wr_data_i[elem_lo(j, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
      if (rd_en_i) rd_data_o <= mem[rd_row_i];
    end
  end

  // COLUMN banks gather element ext_sel_i of every row; otherwise the whole row.
  if (COLUMN) begin : g_col
    always_comb begin
      ext_o = '0;
      for (int i = 0; i < MAX_DIM; i++)
        ext_o[elem_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
          mem[i][elem_lo(int'(ext_sel_i), DATA_WIDTH) +: DATA_WIDTH];
    end
  end else begin : g_row
    assign ext_o = mem[ext_sel_i];
  end

endmodule

// File: rtl/operand_stream_buffer.sv
// rtl/operand_stream_buffer.sv - A/B operand store streaming column k of A and row k of B
module operand_stream_buffer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  localparam int MAX_DIM   = max_dim_of(BUS_WIDTH, DATA_WIDTH),
  localparam int ADDR_W    = addr_w_of(MAX_DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic                 wr_mat_i,
  input  logic [ADDR_W-1:0]    wr_row_i,
  input  logic [BUS_WIDTH-1:0] wr_data_i,
  input  logic [MAX_DIM-1:0]   wr_strb_i,
  input  logic                 rd_en_i,
  input  logic                 rd_mat_i,
  input  logic [ADDR_W-1:0]    rd_row_i,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 start_i,
  input  logic [ADDR_W:0]      n_dim_i,
  input  logic [ADDR_W:0]      k_dim_i,
  input  logic [ADDR_W:0]      m_dim_i,
  output logic [BUS_WIDTH-1:0] a_col_o,
  output logic [BUS_WIDTH-1:0] b_row_o,
  output logic                 vec_valid_o,
  input  logic                 vec_ready_i,
  output logic                 vec_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [ADDR_W:0] MAX_DIM_C = (ADDR_W+1)'(MAX_DIM);
  localparam logic [ADDR_W:0] ONE_C     = (ADDR_W+1)'(1);

  state_t               state_q;
  logic [ADDR_W:0]      n_q, m_q, k_last_q, k_q, k_inc;
  logic [ADDR_W-1:0]    ext_sel;
  logic [BUS_WIDTH-1:0] a_ext, b_ext, a_rd, b_rd;
  logic                 rd_mat_q;
  logic                 wr_ok, xfer, dims_ok;

  assign wr_ok   = wr_en_i && (state_q == ST_IDLE);
  assign xfer    = vec_valid_o && vec_ready_i;
  assign k_inc   = k_q + ONE_C;
  // Extract ports always look at the step the next load will present.
  assign ext_sel = (state_q == ST_IDLE) ? '0 : k_inc[ADDR_W-1:0];
  assign dims_ok = (n_dim_i != '0) && (n_dim_i <= MAX_DIM_C) &&
                   (k_dim_i != '0) && (k_dim_i <= MAX_DIM_C) &&
                   (m_dim_i != '0) && (m_dim_i <= MAX_DIM_C);
  assign rd_data_o = rd_mat_q ? b_rd : a_rd;

  function automatic logic [BUS_WIDTH-1:0] mask_elems(input logic [BUS_WIDTH-1:0] v,
                                                      input logic [ADDR_W:0] dim);
    logic [BUS_WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < MAX_DIM; i++)
      if ((ADDR_W+1)'(i) >= dim) r[elem_lo(i, DATA_WIDTH) +: DATA_WIDTH] = '0;
    return r;
  endfunction

  operand_bank #(
    .DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM),
    .ADDR_W(ADDR_W), .COLUMN(1'b1)
  ) u_bank_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_ok && (wr_mat_i == MAT_A)),
    .wr_row_i  (wr_row_i),
    .wr_data_i (wr_data_i),
    .wr_strb_i (wr_strb_i),
    .rd_en_i   (rd_en_i && (rd_mat_i == MAT_A)),
    .rd_row_i  (rd_row_i),
    .rd_data_o (a_rd),
    .ext_sel_i (ext_sel),
    .ext_o     (a_ext)
  );

  operand_bank #(
    .DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM),
    .ADDR_W(ADDR_W), .COLUMN(1'b0)
  ) u_bank_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_ok && (wr_mat_i == MAT_B)),
    .wr_row_i  (wr_row_i),
    .wr_data_i (wr_data_i),
    .wr_strb_i (wr_strb_i),
    .rd_en_i   (rd_en_i && (rd_mat_i == MAT_B)),
    .rd_row_i  (rd_row_i),
    .rd_data_o (b_rd),
    .ext_sel_i (ext_sel),
    .ext_o     (b_ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      k_last_q    <= '0;
      k_q         <= '0;
      rd_mat_q    <= 1'b0;
      rd_valid_o  <= 1'b0;
      a_col_o     <= '0;
      b_row_o     <= '0;
      vec_valid_o <= 1'b0;
      vec_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      err_o      <= wr_en_i && (state_q != ST_IDLE);
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_mat_q <= rd_mat_i;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (dims_ok) begin
              n_q         <= n_dim_i;
              m_q         <= m_dim_i;
              k_last_q    <= k_dim_i - ONE_C;
              k_q         <= '0;
              a_col_o     <= mask_elems(a_ext, n_dim_i);
              b_row_o     <= mask_elems(b_ext, m_dim_i);
              vec_valid_o <= 1'b1;
              vec_last_o  <= (k_dim_i == ONE_C);
              busy_o      <= 1'b1;
              state_q     <= ST_STREAM;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            if (k_q == k_last_q) begin
              vec_valid_o <= 1'b0;
              vec_last_o  <= 1'b0;
              done_o      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              k_q         <= k_inc;
              a_col_o     <= mask_elems(a_ext, n_q);
              b_row_o     <= mask_elems(b_ext, m_q);
              vec_last_o  <= (k_inc == k_last_q);
            end
          end
        end
        ST_DONE: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
